udp_video_rx_ctrl: RTL and testbench
====================================

# udp_video_rx_ctrl

Receive-side counterpart of the UDP video sender controller. It sits beside `mac_top` in the `gmii_tx_clk` domain. On each `udp_rec_data_valid` pulse it validates the packet length and reads the line header from the UDP receive RAM. It then streams one video line of pixel bytes into a downstream line FIFO, generates frame/line strobes and checks line-number continuity.

## Interface
Parameters:
- `LINE_BYTES`, 1024, pixel bytes per packet/line.
- `RAM_AW`, 11, receive RAM address width.

Ports:
- `gmii_tx_clk`  in  1  block clock; receive RAM read port is on this clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `udp_rec_data_valid`  in  1  one-cycle pulse: a complete UDP payload is in the receive RAM.
- `udp_rec_data_length`  in  16  UDP length field (payload + 8), stable from pulse until the next pulse.
- `udp_rec_ram_read_addr`  out  RAM_AW  registered byte address into the receive RAM.
- `udp_rec_ram_rdata`  in  8  RAM data, valid exactly 1 cycle after the address.
- `fifo_wr_en`  out  1  registered write strobe to the line FIFO.
- `fifo_wr_data`  out  8  pixel byte, qualified by `fifo_wr_en`.
- `fifo_afull`  in  1  FIFO almost-full; asserted with ≥2 free entries margin.
- `frame_start`  out  1  one-cycle pulse when a line with number 1 is accepted.
- `line_done`  out  1  one-cycle pulse after the last byte of a line is written.
- `line_num`  out  16  line number of the most recently accepted packet.
- `seq_err`  out  1  one-cycle pulse when the line number is not last+1 and not 1.
- `len_err`  out  1  one-cycle pulse when the packet length is wrong.
- `drop_cnt`  out  8  saturating count of valid pulses ignored while busy.
- `busy`  out  1  high in every state except IDLE.

## Operation
Payload format:
- Byte 0 = line number[15:8], byte 1 = line number[7:0].
- Bytes 2..LINE_BYTES+1 = pixels.
- Expected `udp_rec_data_length` = LINE_BYTES+10.

States:
- IDLE:
  - On a valid pulse, capture the length.
  - If length ≠ LINE_BYTES+10: pulse `len_err`, go to DROP.
  - Otherwise go to HDR.
- DROP: return to IDLE the next cycle. No RAM reads, no FIFO writes.
- HDR:
  - Issue addresses 0, 1, 2 on consecutive cycles.
  - Form `line_num_next` from bytes 0 and 1, then go to DATA.
- DATA:
  - Issue addresses up to LINE_BYTES+1, advancing only while `fifo_afull` = 0.
  - Every returned pixel byte is written (one write per issued address ≥2).
  - When `fifo_afull` is high, hold the address. The in-flight byte is still written.
  - After the final write go to DONE.
- DONE:
  - Pulse `line_done`, go to IDLE.

Line-number check (one cycle after byte 1 returns):
- Update `line_num`.
- If value = 1, pulse `frame_start`.
- Else if value ≠ previous `line_num`+1 (16-bit wrap, so 0xFFFF→0x0000 is in sequence), pulse `seq_err`.
- The data is still forwarded either way.

Other rules:
- A valid pulse seen in any state other than IDLE is ignored; `drop_cnt` increments and saturates at 255.
- Address arithmetic is RAM_AW bits; LINE_BYTES+1 must be < 2^RAM_AW, otherwise the configuration is illegal.

## Timing
Reset values:
- All outputs 0; `line_num` = 0; state IDLE.
- An asserted reset mid-line abandons the line. No partial line is resumed, and no `line_done` is issued.

Latency with `fifo_afull` low throughout (cycle 0 = valid pulse sampled):
- Addresses 0, 1, 2 appear in cycles 1, 2, 3.
- `line_num`, `frame_start` and `seq_err` update in cycle 4.
- `fifo_wr_en` is high cycles 5..LINE_BYTES+4 with no gaps, carrying bytes 2..LINE_BYTES+1 in order.
- `line_done` pulses in cycle LINE_BYTES+5.
- `busy` falls in cycle LINE_BYTES+6.
- The earliest accepted next pulse is in cycle LINE_BYTES+6.

Back-pressure:
- Each cycle of `fifo_afull` adds exactly one cycle to the line.
- Byte order and count are unchanged.

Error path:
- `len_err` pulses in cycle 1.
- `busy` is high only in cycle 1.

## Test plan
- Reset, then a packet with length 1034, header 0x0001 and a pixel ramp 0..255 repeating → `frame_start` in cycle 4; 1024 contiguous writes cycles 5..1028 matching RAM bytes 2..1025; `line_done` in cycle 1029.
- Lines 1, 2, 4 in sequence → `seq_err` only on line 4; `line_num` = 4; 3072 bytes written in total.
- Length 1000 → `len_err` pulse, zero FIFO writes, `busy` high for 1 cycle; a following valid packet is accepted normally.
- `fifo_afull` held high for 10 cycles mid-line → exactly 1024 writes, in order, with no duplicates or losses; `line_done` 10 cycles later than nominal.
- Second valid pulse during DATA, repeated 300 times → `drop_cnt` saturates at 255; the current line completes intact.
- `rst_n` asserted at cycle 500 of a line → all outputs 0 immediately; the next packet, line 1, streams from byte 2.

Source files
------------

// File: rtl/udp_video_rx_ctrl.sv
// Receives one video line per UDP packet: checks length, reads the line header, streams pixels to the line FIFO.
// Pixels appear 5 cycles after the valid pulse. fifo_afull stalls address issue, and the in-flight byte still lands.
module udp_video_rx_ctrl #(
  parameter int LINE_BYTES = 1024,
  parameter int RAM_AW     = 11
) (
  input  logic              gmii_tx_clk,
  input  logic              rst_n,
  input  logic              udp_rec_data_valid,
  input  logic [15:0]       udp_rec_data_length,
  output logic [RAM_AW-1:0] udp_rec_ram_read_addr,
  input  logic [7:0]        udp_rec_ram_rdata,
  output logic              fifo_wr_en,
  output logic [7:0]        fifo_wr_data,
  input  logic              fifo_afull,
  output logic              frame_start,
  output logic              line_done,
  output logic [15:0]       line_num,
  output logic              seq_err,
  output logic              len_err,
  output logic [7:0]        drop_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, DROP, HDR, DATA, DONE} state_t;

  localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(LINE_BYTES + 1);
  localparam logic [RAM_AW-1:0] PIX_ADDR  = RAM_AW'(2);
  localparam logic [15:0]       EXP_LEN   = 16'(LINE_BYTES + 10);

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              iss_q, iss_d;     // address on the bus is a fresh pixel read
  logic              pend_q, pend_d;   // rdata this cycle is a pixel to write
  logic              last_q, last_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [15:0]       line_num_q, line_num_d;
  logic              frame_start_q, frame_start_d;
  logic              seq_err_q, seq_err_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [15:0]       line_num_next;

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (udp_rec_data_valid) state_d = (udp_rec_data_length == EXP_LEN) ? HDR : DROP;
      DROP: state_d = IDLE;
      HDR:  if (addr_q == PIX_ADDR) state_d = DATA;
      DATA: if (last_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    line_done = (state_q == DONE);
    len_err   = (state_q == DROP);
  end

  assign line_num_next = {hdr_hi_q, udp_rec_ram_rdata};

  always_comb begin
    addr_d        = addr_q;
    iss_d         = 1'b0;
    pend_d        = iss_q;
    last_d        = 1'b0;
    hdr_hi_d      = hdr_hi_q;
    line_num_d    = line_num_q;
    frame_start_d = 1'b0;
    seq_err_d     = 1'b0;
    wr_en_d       = pend_q;
    wr_data_d     = pend_q ? udp_rec_ram_rdata : wr_data_q;
    drop_cnt_d    = drop_cnt_q;

    case (state_q)
      IDLE: addr_d = '0;
      HDR: begin
        if (addr_q != PIX_ADDR) begin
          addr_d = addr_q + RAM_AW'(1);
          iss_d  = (addr_q == RAM_AW'(1));
          if (addr_q == RAM_AW'(1)) hdr_hi_d = udp_rec_ram_rdata;
        end else begin
          line_num_d = line_num_next;
          if (line_num_next == 16'd1) frame_start_d = 1'b1;
          else if (line_num_next != line_num_q + 16'd1) seq_err_d = 1'b1;
          if (!fifo_afull) begin
            addr_d = addr_q + RAM_AW'(1);
            iss_d  = 1'b1;
          end
        end
      end
      DATA: begin
        if (!fifo_afull && addr_q != LAST_ADDR) begin
          addr_d = addr_q + RAM_AW'(1);
          iss_d  = 1'b1;
        end
        // final byte is in flight; line_done follows the cycle after its write
        last_d = pend_q && !iss_q && (addr_q == LAST_ADDR);
      end
      default: ;
    endcase

    if (udp_rec_data_valid && state_q != IDLE && drop_cnt_q != 8'hFF)
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      iss_q         <= 1'b0;
      pend_q        <= 1'b0;
      last_q        <= 1'b0;
      hdr_hi_q      <= '0;
      line_num_q    <= '0;
      frame_start_q <= 1'b0;
      seq_err_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      addr_q        <= addr_d;
      iss_q         <= iss_d;
      pend_q        <= pend_d;
      last_q        <= last_d;
      hdr_hi_q      <= hdr_hi_d;
      line_num_q    <= line_num_d;
      frame_start_q <= frame_start_d;
      seq_err_q     <= seq_err_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign udp_rec_ram_read_addr = addr_q;
  assign fifo_wr_en            = wr_en_q;
  assign fifo_wr_data          = wr_data_q;
  assign frame_start           = frame_start_q;
  assign seq_err               = seq_err_q;
  assign line_num              = line_num_q;
  assign drop_cnt              = drop_cnt_q;

endmodule

// File: tb/tb_udp_video_rx_ctrl.sv
// Directed packet sequence with random pixels, checked against a packet-level reference model.
module tb_udp_video_rx_ctrl;
  localparam int LB = 1024;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n, valid, afull;
  logic [15:0]   len;
  logic [AW-1:0] addr;
  logic [7:0]    rdata, wr_data, dc;
  logic          wr_en, fs, ld, se, le, busy;
  logic [15:0]   ln;

  always #5 clk = ~clk;

  udp_video_rx_ctrl #(.LINE_BYTES(LB), .RAM_AW(AW)) dut (
    .gmii_tx_clk(clk), .rst_n(rst_n),
    .udp_rec_data_valid(valid), .udp_rec_data_length(len),
    .udp_rec_ram_read_addr(addr), .udp_rec_ram_rdata(rdata),
    .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_afull(afull),
    .frame_start(fs), .line_done(ld), .line_num(ln), .seq_err(se),
    .len_err(le), .drop_cnt(dc), .busy(busy)
  );

  logic [7:0] ram [0:2047];
  always @(posedge clk) rdata <= ram[addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int t0 = 0;
  logic [7:0] exp_pix [0:LB-1];
  int wr_cnt, first_wr, last_wr, mism, ld_cnt, ld_rel, fs_cnt, fs_rel, se_cnt, le_cnt, le_rel, busy_cnt;
  int total_wr = 0;
  logic [15:0] model_ln = 16'd0;
  int model_drops = 0;

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (busy) busy_cnt++;
    if (wr_en) begin
      if (wr_cnt == 0) first_wr = rel;
      last_wr = rel;
      if (wr_cnt >= LB || wr_data !== exp_pix[wr_cnt]) mism++;
      wr_cnt++;
      total_wr++;
    end
    if (ld) begin ld_cnt++; ld_rel = rel; end
    if (fs) begin fs_cnt++; fs_rel = rel; end
    if (se) se_cnt++;
    if (le) begin le_cnt++; le_rel = rel; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {25'd0, wr_en, fs, ld, se, le, busy, 1'b0}, 32'd0);
    chk({tag, "_dat"}, {wr_data, dc, ln}, 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
  endtask

  task automatic run_pkt(input logic [15:0] lnum, input logic [15:0] plen, input bit ramp,
                         input int af_start, input int af_len, input int drops, input int rst_at);
    bit ok, done, aborted, exp_fs, exp_se;
    int k, sent;
    ok = (plen == 16'(LB + 10));
    ram[0] = lnum[15:8];
    ram[1] = lnum[7:0];
    for (int i = 0; i < LB; i++) begin
      ram[2+i]   = ramp ? 8'(i) : 8'($urandom);
      exp_pix[i] = ram[2+i];
    end
    wr_cnt = 0; first_wr = -1; last_wr = -1; mism = 0; ld_cnt = 0; ld_rel = -1;
    fs_cnt = 0; fs_rel = -1; se_cnt = 0; le_cnt = 0; le_rel = -1; busy_cnt = 0;
    @(posedge clk); #1;
    len = plen; valid = 1'b1; t0 = cyc;
    k = 0; sent = 0; done = 0; aborted = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1;
      k++;
      valid = 1'b0;
      if (sent < drops && k >= 10 && (k % 3) == 1) begin valid = 1'b1; sent++; end
      afull = (k >= af_start && k < af_start + af_len);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midline_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        aborted = 1; done = 1;
      end else if (!busy && k > 1) begin
        done = 1;
      end
    end
    valid = 1'b0; afull = 1'b0;
    chk("pkt_finished", 32'(done), 32'd1);
    if (aborted) begin
      chk("abort_no_line_done", 32'(ld_cnt), 32'd0);
      model_ln = 16'd0;
      model_drops = 0;
    end else if (ok) begin
      exp_fs = (lnum == 16'd1);
      exp_se = !exp_fs && (lnum != model_ln + 16'd1);
      model_ln = lnum;
      model_drops = (model_drops + drops > 255) ? 255 : model_drops + drops;
      chk("wr_count", 32'(wr_cnt), 32'(LB));
      chk("wr_data_mismatches", 32'(mism), 32'd0);
      chk("first_wr_cycle", 32'(first_wr), 32'd5);
      chk("last_wr_cycle", 32'(last_wr), 32'(LB + 4 + af_len));
      chk("line_done_count", 32'(ld_cnt), 32'd1);
      chk("line_done_cycle", 32'(ld_rel), 32'(LB + 5 + af_len));
      chk("busy_cycles", 32'(busy_cnt), 32'(LB + 5 + af_len));
      chk("frame_start_count", 32'(fs_cnt), 32'(exp_fs));
      if (exp_fs) chk("frame_start_cycle", 32'(fs_rel), 32'd4);
      chk("seq_err_count", 32'(se_cnt), 32'(exp_se));
      chk("len_err_none", 32'(le_cnt), 32'd0);
      chk("line_num", 32'(ln), 32'(model_ln));
      chk("drop_cnt", 32'(dc), 32'(model_drops));
    end else begin
      chk("len_err_count", 32'(le_cnt), 32'd1);
      chk("len_err_cycle", 32'(le_rel), 32'd1);
      chk("len_err_no_writes", 32'(wr_cnt), 32'd0);
      chk("len_err_busy_cycles", 32'(busy_cnt), 32'd1);
      chk("len_err_no_line_done", 32'(ld_cnt), 32'd0);
      chk("len_err_line_num", 32'(ln), 32'(model_ln));
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; afull = 1'b0; len = 16'd0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_pkt(16'd1, 16'(LB + 10), 1'b1, 0, 0, 0, 0);
    total_wr = 0;
    run_pkt(16'd1, 16'(LB + 10), 1'b0, 0, 0, 0, 0);
    run_pkt(16'd2, 16'(LB + 10), 1'b0, 0, 0, 0, 0);
    run_pkt(16'd4, 16'(LB + 10), 1'b0, 0, 0, 0, 0);
    chk("three_line_total", 32'(total_wr), 32'(3 * LB));

    run_pkt(16'd5, 16'd1000, 1'b0, 0, 0, 0, 0);
    run_pkt(16'd5, 16'(LB + 10), 1'b0, 0, 0, 0, 0);

    run_pkt(16'd6, 16'(LB + 10), 1'b0, 300 + 16'($urandom_range(0, 400)), 10, 0, 0);
    run_pkt(16'd7, 16'(LB + 10), 1'b0, 0, 0, 300, 0);
    chk("drop_cnt_saturated", 32'(dc), 32'd255);

    run_pkt(16'd8, 16'(LB + 10), 1'b0, 0, 0, 0, 500);
    chk("post_reset_line_num", 32'(ln), 32'd0);
    run_pkt(16'd1, 16'(LB + 10), 1'b1, 0, 0, 0, 0);

    run_pkt(16'hFFFF, 16'(LB + 10), 1'b0, 0, 0, 0, 0);
    run_pkt(16'h0000, 16'(LB + 10), 1'b0, 0, 0, 0, 0);
    run_pkt(16'($urandom_range(3, 60000)), 16'(LB + 10), 1'b0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
